// File: rtl/rob_param.sv
// Parameterised re-order buffer: in-order retire of up to WAYS completed entries per cycle,
// partial-accept dispatch, mispredict flush with pointer rollback and a sticky halt.
module rob_param #(
    parameter int N_ENTRIES = 32,
    parameter int WAYS      = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WAYS-1:0]        disp_valid,
    input  logic [WAYS*TAG_W-1:0]  disp_t_idx,
    input  logic [WAYS*TAG_W-1:0]  disp_told_idx,
    input  logic [WAYS*5-1:0]      disp_ar_idx,
    input  logic [WAYS-1:0]        disp_halt,
    input  logic [WAYS*DATA_W-1:0] disp_npc,
    output logic [WAYS-1:0]        disp_ready,
    output logic [WAYS*IDX_W-1:0]  disp_rob_idx,
    input  logic [WAYS-1:0]        cmp_valid,
    input  logic [WAYS*IDX_W-1:0]  cmp_rob_idx,
    input  logic [WAYS*DATA_W-1:0] cmp_value,
    input  logic [WAYS-1:0]        cmp_mispredict,
    input  logic [WAYS*DATA_W-1:0] cmp_target_pc,
    output logic [WAYS-1:0]        ret_valid,
    output logic [WAYS*TAG_W-1:0]  ret_t_idx,
    output logic [WAYS*TAG_W-1:0]  ret_told_idx,
    output logic [WAYS*5-1:0]      ret_ar_idx,
    output logic [WAYS*DATA_W-1:0] ret_value,
    output logic [WAYS*DATA_W-1:0] ret_npc,
    output logic [WAYS-1:0]        ret_halt,
    output logic                   flush,
    output logic [DATA_W-1:0]      flush_pc,
    output logic                   halted,
    output logic [IDX_W:0]         count,
    output logic                   full,
    output logic                   empty
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(N_ENTRIES);

    logic [N_ENTRIES-1:0] valid_q, valid_d, complete_q, complete_d;
    logic [N_ENTRIES-1:0] mispred_q, mispred_d, halt_q, halt_d;
    logic [TAG_W-1:0]     t_q [N_ENTRIES];
    logic [TAG_W-1:0]     t_d [N_ENTRIES];
    logic [TAG_W-1:0]     told_q [N_ENTRIES];
    logic [TAG_W-1:0]     told_d [N_ENTRIES];
    logic [4:0]           ar_q [N_ENTRIES];
    logic [4:0]           ar_d [N_ENTRIES];
    logic [DATA_W-1:0]    value_q [N_ENTRIES];
    logic [DATA_W-1:0]    value_d [N_ENTRIES];
    logic [DATA_W-1:0]    npc_q [N_ENTRIES];
    logic [DATA_W-1:0]    npc_d [N_ENTRIES];
    logic [DATA_W-1:0]    target_q [N_ENTRIES];
    logic [DATA_W-1:0]    target_d [N_ENTRIES];
    logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 halted_q, halted_d;

    logic [CNT_W-1:0]     n_ret, n_acc, n_req, free;
    logic                 chain, halt_ret;
    logic [IDX_W-1:0]     ridx, xidx, cidx, widx;

    // Retire window: stops after the first mispredict or halt so nothing younger leaves with it.
    always_comb begin
        ret_valid    = '0;
        ret_t_idx    = '0;
        ret_told_idx = '0;
        ret_ar_idx   = '0;
        ret_value    = '0;
        ret_npc      = '0;
        ret_halt     = '0;
        flush        = 1'b0;
        flush_pc     = '0;
        halt_ret     = 1'b0;
        n_ret        = '0;
        chain        = ~halted_q;
        ridx         = '0;
        for (int i = 0; i < WAYS; i++) begin
            ridx         = head_q + IDX_W'(i);
            ret_valid[i] = chain & valid_q[ridx] & complete_q[ridx];
            chain        = ret_valid[i] & ~mispred_q[ridx] & ~halt_q[ridx];
            if (ret_valid[i]) begin
                ret_t_idx[i*TAG_W +: TAG_W]    = t_q[ridx];
                ret_told_idx[i*TAG_W +: TAG_W] = told_q[ridx];
                ret_ar_idx[i*5 +: 5]           = ar_q[ridx];
                ret_value[i*DATA_W +: DATA_W]  = value_q[ridx];
                ret_npc[i*DATA_W +: DATA_W]    = npc_q[ridx];
                ret_halt[i]                    = halt_q[ridx];
                n_ret                          = n_ret + CNT_W'(1);
                if (mispred_q[ridx]) begin
                    flush    = 1'b1;
                    flush_pc = target_q[ridx];
                end
                if (halt_q[ridx]) begin
                    halt_ret = 1'b1;
                end
            end
        end
    end

    // Free space is measured before this cycle's retires, so accepted ways are always a prefix.
    always_comb begin
        disp_ready   = '0;
        disp_rob_idx = '0;
        n_req        = '0;
        n_acc        = '0;
        free         = DEPTH - count_q;
        for (int i = 0; i < WAYS; i++) begin
            if (disp_valid[i]) begin
                n_req = n_req + CNT_W'(1);
            end
            if (disp_valid[i] && !flush && !halted_q && (n_req <= free)) begin
                disp_ready[i]                    = 1'b1;
                disp_rob_idx[i*IDX_W +: IDX_W]   = tail_q + n_acc[IDX_W-1:0];
                n_acc                            = n_acc + CNT_W'(1);
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        mispred_d  = mispred_q;
        halt_d     = halt_q;
        t_d        = t_q;
        told_d     = told_q;
        ar_d       = ar_q;
        value_d    = value_q;
        npc_d      = npc_q;
        target_d   = target_q;
        head_d     = head_q + n_ret[IDX_W-1:0];
        tail_d     = tail_q + n_acc[IDX_W-1:0];
        count_d    = count_q + n_acc - n_ret;
        halted_d   = halted_q | halt_ret;
        cidx       = '0;
        xidx       = '0;
        widx       = '0;
        if (flush) begin
            valid_d    = '0;
            complete_d = '0;
            mispred_d  = '0;
            halt_d     = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                cidx = cmp_rob_idx[w*IDX_W +: IDX_W];
                if (cmp_valid[w] && valid_q[cidx]) begin
                    complete_d[cidx] = 1'b1;
                    mispred_d[cidx]  = cmp_mispredict[w];
                    value_d[cidx]    = cmp_value[w*DATA_W +: DATA_W];
                    target_d[cidx]   = cmp_target_pc[w*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < WAYS; i++) begin
                xidx = head_q + IDX_W'(i);
                if (ret_valid[i]) begin
                    valid_d[xidx]    = 1'b0;
                    complete_d[xidx] = 1'b0;
                    mispred_d[xidx]  = 1'b0;
                    halt_d[xidx]     = 1'b0;
                end
            end
            for (int i = 0; i < WAYS; i++) begin
                widx = disp_rob_idx[i*IDX_W +: IDX_W];
                if (disp_ready[i]) begin
                    valid_d[widx]    = 1'b1;
                    complete_d[widx] = 1'b0;
                    mispred_d[widx]  = 1'b0;
                    halt_d[widx]     = disp_halt[i];
                    t_d[widx]        = disp_t_idx[i*TAG_W +: TAG_W];
                    told_d[widx]     = disp_told_idx[i*TAG_W +: TAG_W];
                    ar_d[widx]       = disp_ar_idx[i*5 +: 5];
                    npc_d[widx]      = disp_npc[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            complete_q <= '0;
            mispred_q  <= '0;
            halt_q     <= '0;
            t_q        <= '{default: '0};
            told_q     <= '{default: '0};
            ar_q       <= '{default: '0};
            value_q    <= '{default: '0};
            npc_q      <= '{default: '0};
            target_q   <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            mispred_q  <= mispred_d;
            halt_q     <= halt_d;
            t_q        <= t_d;
            told_q     <= told_d;
            ar_q       <= ar_d;
            value_q    <= value_d;
            npc_q      <= npc_d;
            target_q   <= target_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    assign count  = count_q;
    assign full   = (count_q == DEPTH);
    assign empty  = (count_q == '0);
    assign halted = halted_q;

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: scenario tasks with inline checks plus a retire-order scoreboard.
module tb_rob_param;

    localparam int N  = 32;
    localparam int W  = 2;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int IW = 5;

    logic clock, reset_n;
    logic [W-1:0]    disp_valid, disp_halt, disp_ready;
    logic [W*TW-1:0] disp_t_idx, disp_told_idx;
    logic [W*5-1:0]  disp_ar_idx;
    logic [W*DW-1:0] disp_npc;
    logic [W*IW-1:0] disp_rob_idx;
    logic [W-1:0]    cmp_valid, cmp_mispredict;
    logic [W*IW-1:0] cmp_rob_idx;
    logic [W*DW-1:0] cmp_value, cmp_target_pc;
    logic [W-1:0]    ret_valid, ret_halt;
    logic [W*TW-1:0] ret_t_idx, ret_told_idx;
    logic [W*5-1:0]  ret_ar_idx;
    logic [W*DW-1:0] ret_value, ret_npc;
    logic            flush, halted, full, empty;
    logic [DW-1:0]   flush_pc;
    logic [IW:0]     count;

    rob_param #(.N_ENTRIES(N), .WAYS(W), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_valid(disp_valid), .disp_t_idx(disp_t_idx), .disp_told_idx(disp_told_idx),
        .disp_ar_idx(disp_ar_idx), .disp_halt(disp_halt), .disp_npc(disp_npc),
        .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
        .cmp_valid(cmp_valid), .cmp_rob_idx(cmp_rob_idx), .cmp_value(cmp_value),
        .cmp_mispredict(cmp_mispredict), .cmp_target_pc(cmp_target_pc),
        .ret_valid(ret_valid), .ret_t_idx(ret_t_idx), .ret_told_idx(ret_told_idx),
        .ret_ar_idx(ret_ar_idx), .ret_value(ret_value), .ret_npc(ret_npc), .ret_halt(ret_halt),
        .flush(flush), .flush_pc(flush_pc), .halted(halted),
        .count(count), .full(full), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] idx;
        logic [TW-1:0] t;
        logic [TW-1:0] told;
        logic [4:0]    ar;
        logic [DW-1:0] npc;
        logic          halt;
    } sb_t;

    sb_t           sb[$];
    sb_t           mon_e;
    logic [DW-1:0] exp_val [N];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            serial  = 0;
    logic [TW-1:0] pend_t [W];
    logic [TW-1:0] pend_told [W];
    logic [4:0]    pend_ar [W];
    logic [DW-1:0] pend_npc [W];
    logic          pend_halt [W];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        disp_valid = '0; disp_halt = '0; disp_t_idx = '0; disp_told_idx = '0;
        disp_ar_idx = '0; disp_npc = '0;
        cmp_valid = '0; cmp_rob_idx = '0; cmp_value = '0; cmp_mispredict = '0; cmp_target_pc = '0;
    endtask

    task automatic disp_set(input logic [W-1:0] v, input logic [W-1:0] h);
        for (int i = 0; i < W; i++) begin
            pend_t[i]    = TW'((serial + i) * 7 + 3);
            pend_told[i] = TW'(serial + i);
            pend_ar[i]   = 5'((serial + i) * 3);
            pend_npc[i]  = 32'h1000 + DW'(serial + i) * 4;
            pend_halt[i] = h[i];
            disp_t_idx[i*TW +: TW]    = pend_t[i];
            disp_told_idx[i*TW +: TW] = pend_told[i];
            disp_ar_idx[i*5 +: 5]     = pend_ar[i];
            disp_npc[i*DW +: DW]      = pend_npc[i];
        end
        disp_valid = v;
        disp_halt  = h;
        serial     = serial + W;
    endtask

    task automatic sb_push(input int way, input int idx);
        sb.push_back('{idx: IW'(idx), t: pend_t[way], told: pend_told[way], ar: pend_ar[way],
                       npc: pend_npc[way], halt: pend_halt[way]});
    endtask

    task automatic cmp_set(input int way, input int idx, input logic [DW-1:0] val,
                           input logic mp, input logic [DW-1:0] tgt);
        cmp_valid[way]              = 1'b1;
        cmp_rob_idx[way*IW +: IW]   = IW'(idx);
        cmp_value[way*DW +: DW]     = val;
        cmp_mispredict[way]         = mp;
        cmp_target_pc[way*DW +: DW] = tgt;
        exp_val[idx]                = val;
    endtask

    task automatic reset_dut();
        clr_inputs();
        reset_n = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) exp_val[i] = '0;
        serial = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Retire monitor: every retiring way must match the oldest outstanding dispatch.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < W; i++) begin
                if (ret_valid[i]) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_underflow way %0d got a retire, expected none", i);
                    end else begin
                        mon_e = sb.pop_front();
                        if ({ret_t_idx[i*TW +: TW], ret_told_idx[i*TW +: TW], ret_ar_idx[i*5 +: 5],
                             ret_npc[i*DW +: DW], ret_halt[i]} !==
                            {mon_e.t, mon_e.told, mon_e.ar, mon_e.npc, mon_e.halt}) begin
                            n_fail++;
                            $display("FAIL sb_fields way %0d got t=%h told=%h ar=%h npc=%h halt=%b exp t=%h told=%h ar=%h npc=%h halt=%b",
                                     i, ret_t_idx[i*TW +: TW], ret_told_idx[i*TW +: TW], ret_ar_idx[i*5 +: 5],
                                     ret_npc[i*DW +: DW], ret_halt[i], mon_e.t, mon_e.told, mon_e.ar, mon_e.npc, mon_e.halt);
                        end
                        n_tests++;
                        if (ret_value[i*DW +: DW] !== exp_val[mon_e.idx]) begin
                            n_fail++;
                            $display("FAIL sb_value way %0d got %h exp %h", i, ret_value[i*DW +: DW], exp_val[mon_e.idx]);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset_dut();
        n_tests++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_tests++; if ({ret_valid, disp_ready, flush, halted} !== 6'b0) begin n_fail++; $display("FAIL reset_outputs got %b exp 000000", {ret_valid, disp_ready, flush, halted}); end
        n_tests++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got %h exp 0", flush_pc); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 16; c++) begin
            disp_set(2'b11, 2'b00);
            #1;
            n_tests++; if (disp_ready !== 2'b11) begin n_fail++; $display("FAIL fill_ready c%0d got %b exp 11", c, disp_ready); end
            n_tests++; if (disp_rob_idx !== {5'(2*c+1), 5'(2*c)}) begin n_fail++; $display("FAIL fill_idx c%0d got %h exp %h", c, disp_rob_idx, {5'(2*c+1), 5'(2*c)}); end
            sb_push(0, 2*c);
            sb_push(1, 2*c+1);
            step();
        end
        clr_inputs();
        n_tests++; if (count !== 6'd32) begin n_fail++; $display("FAIL fill_count got %0d exp 32", count); end
        n_tests++; if ({full, empty} !== 2'b10) begin n_fail++; $display("FAIL fill_flags got %b exp 10", {full, empty}); end
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if (disp_ready !== 2'b00) begin n_fail++; $display("FAIL fill_full_ready got %b exp 00", disp_ready); end
        n_tests++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL fill_ret got %b exp 00", ret_valid); end
        clr_inputs();
        step();
    endtask

    task automatic test_wrap();
        cmp_set(0, 0, 32'hA5A5_0000, 1'b0, 32'h0);
        #1;
        n_tests++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL wrap_early_ret got %b exp 00", ret_valid); end
        step();
        clr_inputs();
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if (ret_valid !== 2'b01) begin n_fail++; $display("FAIL wrap_ret got %b exp 01", ret_valid); end
        n_tests++; if (ret_t_idx[TW-1:0] !== 6'd3) begin n_fail++; $display("FAIL wrap_ret_t got %0d exp 3", ret_t_idx[TW-1:0]); end
        n_tests++; if (disp_ready !== 2'b00) begin n_fail++; $display("FAIL wrap_no_reuse got %b exp 00", disp_ready); end
        step();
        clr_inputs();
        n_tests++; if (count !== 6'd31) begin n_fail++; $display("FAIL wrap_count got %0d exp 31", count); end
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if (disp_ready !== 2'b01) begin n_fail++; $display("FAIL wrap_partial got %b exp 01", disp_ready); end
        n_tests++; if (disp_rob_idx[IW-1:0] !== 5'd0) begin n_fail++; $display("FAIL wrap_idx got %0d exp 0", disp_rob_idx[IW-1:0]); end
        sb_push(0, 0);
        step();
        clr_inputs();
        n_tests++; if ({count, full} !== {6'd32, 1'b1}) begin n_fail++; $display("FAIL wrap_refull got %0d/%b exp 32/1", count, full); end
    endtask

    task automatic test_inorder();
        reset_dut();
        disp_set(2'b10, 2'b00);
        #1;
        n_tests++; if ({disp_ready, disp_rob_idx[2*IW-1:IW]} !== {2'b10, 5'd0}) begin n_fail++; $display("FAIL skip_way got %b/%0d exp 10/0", disp_ready, disp_rob_idx[2*IW-1:IW]); end
        sb_push(1, 0);
        step();
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if (disp_rob_idx !== {5'd2, 5'd1}) begin n_fail++; $display("FAIL inorder_idx got %h exp %h", disp_rob_idx, {5'd2, 5'd1}); end
        sb_push(0, 1);
        sb_push(1, 2);
        step();
        disp_set(2'b01, 2'b00);
        sb_push(0, 3);
        step();
        clr_inputs();
        for (int k = 3; k >= 0; k--) begin
            clr_inputs();
            cmp_set(0, k, 32'h100 + DW'(k), 1'b0, 32'h0);
            #1;
            n_tests++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL inorder_hold k%0d got %b exp 00", k, ret_valid); end
            step();
        end
        clr_inputs();
        n_tests++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL inorder_ret1 got %b exp 11", ret_valid); end
        step();
        n_tests++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL inorder_ret2 got %b exp 11", ret_valid); end
        step();
        n_tests++; if ({empty, count, ret_valid} !== {1'b1, 6'd0, 2'b00}) begin n_fail++; $display("FAIL inorder_drained got %b/%0d/%b exp 1/0/00", empty, count, ret_valid); end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            disp_set(2'b11, 2'b00);
            sb_push(0, 2*c);
            sb_push(1, 2*c+1);
            step();
        end
        clr_inputs();
        cmp_set(0, 2, 32'h22, 1'b0, 32'h0);
        cmp_set(1, 3, 32'h33, 1'b0, 32'h0);
        step();
        clr_inputs();
        cmp_set(0, 4, 32'h44, 1'b0, 32'h0);
        cmp_set(1, 5, 32'h55, 1'b0, 32'h0);
        #1;
        n_tests++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL flush_pre_ret got %b exp 00", ret_valid); end
        step();
        clr_inputs();
        cmp_set(0, 0, 32'h11, 1'b0, 32'h0);
        cmp_set(1, 1, 32'hBB, 1'b1, 32'h400);
        step();
        clr_inputs();
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if ({ret_valid, flush} !== 3'b111) begin n_fail++; $display("FAIL flush_ret got %b exp 111", {ret_valid, flush}); end
        n_tests++; if (flush_pc !== 32'h400) begin n_fail++; $display("FAIL flush_pc got %h exp 400", flush_pc); end
        n_tests++; if (disp_ready !== 2'b00) begin n_fail++; $display("FAIL flush_disp got %b exp 00", disp_ready); end
        step();
        clr_inputs();
        sb.delete();
        n_tests++; if ({count, empty, ret_valid, flush} !== {6'd0, 1'b1, 2'b00, 1'b0}) begin n_fail++; $display("FAIL flush_after got %0d/%b/%b/%b exp 0/1/00/0", count, empty, ret_valid, flush); end
        disp_set(2'b01, 2'b00);
        #1;
        n_tests++; if ({disp_ready, disp_rob_idx[IW-1:0]} !== {2'b01, 5'd0}) begin n_fail++; $display("FAIL flush_tail got %b/%0d exp 01/0", disp_ready, disp_rob_idx[IW-1:0]); end
        sb_push(0, 0);
        step();
        clr_inputs();
        n_tests++; if (count !== 6'd1) begin n_fail++; $display("FAIL flush_count1 got %0d exp 1", count); end
    endtask

    task automatic test_halt();
        reset_dut();
        disp_set(2'b11, 2'b01);
        sb_push(0, 0);
        sb_push(1, 1);
        step();
        clr_inputs();
        cmp_set(0, 0, 32'hD0, 1'b0, 32'h0);
        cmp_set(1, 1, 32'hD1, 1'b0, 32'h0);
        step();
        clr_inputs();
        #1;
        n_tests++; if ({ret_valid, ret_halt, halted} !== 5'b01010) begin n_fail++; $display("FAIL halt_ret got %b exp 01010", {ret_valid, ret_halt, halted}); end
        step();
        n_tests++; if ({halted, ret_valid, count} !== {1'b1, 2'b00, 6'd1}) begin n_fail++; $display("FAIL halt_block got %b/%b/%0d exp 1/00/1", halted, ret_valid, count); end
        disp_set(2'b11, 2'b00);
        #1;
        n_tests++; if (disp_ready !== 2'b00) begin n_fail++; $display("FAIL halt_disp got %b exp 00", disp_ready); end
        step();
        clr_inputs();
        n_tests++; if ({halted, count} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL halt_sticky got %b/%0d exp 1/1", halted, count); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int c = 0; c < 6; c++) begin
            disp_set(2'b11, 2'b00);
            if (c == 5) cmp_set(0, 0, 32'hEE, 1'b0, 32'h0);
            sb_push(0, 2*c);
            sb_push(1, 2*c+1);
            step();
            clr_inputs();
        end
        n_tests++; if ({count, ret_valid} !== {6'd12, 2'b01}) begin n_fail++; $display("FAIL areset_pre got %0d/%b exp 12/01", count, ret_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if ({count, empty, full, ret_valid} !== {6'd0, 1'b1, 1'b0, 2'b00}) begin n_fail++; $display("FAIL areset_now got %0d/%b/%b/%b exp 0/1/0/00", count, empty, full, ret_valid); end
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        test_reset();
        test_fill();
        test_wrap();
        test_inorder();
        test_flush();
        test_halt();
        test_async_reset();
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached, bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised second-generation re-order buffer for the out-of-order core. Sits between dispatch, complete and retire.
- Generalised in depth, superscalar width and tag/data widths.
- Adds four things the current ROB does not have:
  - occupancy counter with explicit full/empty flags
  - partial-accept dispatch handshake
  - mispredict-triggered flush with pointer rollback
  - sticky halt

Parameters:
- N_ENTRIES, 32, ROB depth; power of 2, at least 4.
- WAYS, 2, dispatch/complete/retire ports per cycle; 1..4, and at most N_ENTRIES/2.
- TAG_W, 6, physical register index width.
- DATA_W, 32, result/PC width.
- IDX_W, $clog2(N_ENTRIES), ROB index width (derived).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  WAYS  dispatch request per way.
- disp_t_idx  in  WAYS*TAG_W  new physical dest tag.
- disp_told_idx  in  WAYS*TAG_W  previous physical tag.
- disp_ar_idx  in  WAYS*5  architectural dest register.
- disp_halt  in  WAYS  instruction is a halt.
- disp_npc  in  WAYS*DATA_W  next PC.
- disp_ready  out  WAYS  way accepted this cycle.
- disp_rob_idx  out  WAYS*IDX_W  allocated entry index per accepted way.
- cmp_valid  in  WAYS  completion strobe.
- cmp_rob_idx  in  WAYS*IDX_W  completing entry.
- cmp_value  in  WAYS*DATA_W  result value.
- cmp_mispredict  in  WAYS  branch resolved mispredicted.
- cmp_target_pc  in  WAYS*DATA_W  correct target PC.
- ret_valid  out  WAYS  entry retiring this cycle, way 0 = oldest.
- ret_t_idx, ret_told_idx, ret_ar_idx, ret_value, ret_npc, ret_halt  out  per-way widths as above  retired entry fields.
- flush  out  1  pipeline flush request.
- flush_pc  out  DATA_W  redirect PC.
- halted  out  1  halt has retired.
- count  out  IDX_W+1  occupied entries.
- full  out  1  count == N_ENTRIES.
- empty  out  1  count == 0.

Behaviour:
- State:
  - entries: valid, complete, mispredict, halt, t, told, ar, value, npc, target.
  - head, tail (IDX_W each; natural wrap-around).
  - count (IDX_W+1).
  - halted_q.
- Async reset (reset_n low):
  - all entries cleared; head = tail = count = 0; halted_q = 0.
  - All outputs 0 except empty = 1.
  - Reset asserted mid-operation discards all state immediately.
- Retire (combinational from registered state, zero latency):
  - ret_valid[0] = ~halted_q & entry[head].valid & entry[head].complete.
  - ret_valid[i] = ret_valid[i-1] & entry[head+i] valid & complete & ~mispredict[head+i-1] & ~halt[head+i-1].
  - Retire fields are driven only where ret_valid is set; otherwise 0.
  - Retired entries are cleared at the next edge; head += number retired.
- Flush:
  - flush = 1 when any retiring way has mispredict set; flush_pc = that entry's target.
  - At the next edge: all entries invalidated, head = tail = count = 0.
  - Completions and dispatches in the flush cycle are discarded; disp_ready = 0 while flush = 1.
- Halt:
  - A retiring halt sets halted_q at the next edge.
  - While halted_q = 1: retirement and dispatch are blocked (disp_ready = 0, ret_valid = 0) until reset.
- Dispatch:
  - free = N_ENTRIES - count, taken before this cycle's retires; freed slots are never reused in the same cycle.
  - Valid ways receive consecutive indices from tail in way order; invalid ways are skipped.
  - disp_ready[i] = disp_valid[i] & ~flush & ~halted_q & (number of valid ways at positions 0..i) <= free.
  - tail advances by the number accepted.
  - A new entry is written with valid = 1 and complete = mispredict = 0.
- Complete:
  - Sets complete, value, mispredict and target at the next edge.
  - Ignored when the target entry is invalid or flush = 1.
  - A completion never aliases a dispatch slot in the same cycle (the slot is invalid).
  - Duplicate indices in one cycle: the highest way wins.
- count_next = count + accepted - retired.
- When tail == head: occupancy is disambiguated solely by count.

Test Plan:
- Reset, then dispatch WAYS=2 both valid for 16 cycles (N=32) -> indices 0..31 allocated in order. full = 1 and count = 32 at cycle 16. Cycle 17 disp_ready = 00.
- Full ROB; complete entry 0 only -> one cycle later ret_valid = 01 with ret_t_idx matching entry 0. Next cycle count = 31, head = 1, one dispatch accepted with index 0 (wrap-around).
- Entries 0..3 allocated; complete 3, 2, 1, 0 in reverse order over 4 cycles -> nothing retires until entry 0 completes, then 2 per cycle over 2 cycles. Empty = 1 after.
- Entry 1 completes with cmp_mispredict, target 0x400; entries 0..5 allocated and 0..5 complete -> ret_valid = 11 with flush = 1 and flush_pc = 0x400 that cycle. Dispatch that cycle gets disp_ready = 00. Next cycle count = 0, empty = 1, head = tail = 0.
- Halt at entry 0, entry 1 complete -> ret_valid = 01 and ret_halt = 1. halted = 1 thereafter; no further retire or dispatch.
- Assert reset_n low mid-stream with count = 12, asynchronously between edges -> count = 0, empty = 1, ret_valid = 0 immediately, before the next clock edge.
